// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// datapath
//   32-bit execution datapath: a 16 x 32-bit register file feeding an
//   ALU/multiplier. Each cycle the sequencer presents decoded control fields;
//   results are written back on the next rising clock edge. Register 15 is
//   also the program counter.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset, clears every register
//   op[2:0]      ALU operation (add, sub, and, or, mul, xor, shl, shr)
//   form         second-operand select when const_c=0 (0: reg[C], 1: reg[B])
//   vec[1:0]     lane mode for add/sub/logic (01: 2x16, 10: 4x8, else 1x32)
//   A, B, C, D   register addresses (first operand, alt second, second, copy src)
//   Y1, Y2       primary / secondary destination registers
//   write[1:0]   bit0 enables the Y1 write, bit1 enables the Y2 write
//   const_c      1: second operand is the immediate `constant`
//   constant     32-bit immediate
//   pc_inc       advance r15 by 4 unless it is written this cycle
//   copy_select  byte mask choosing reg[D] bytes for the Y2 merge
//   pc           current value of registers[15]
// ---------------------------------------------------------------------------
module datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  op,
  input  logic        form,
  input  logic [1:0]  vec,
  input  logic [3:0]  A,
  input  logic [3:0]  B,
  input  logic [3:0]  C,
  input  logic [3:0]  D,
  input  logic [3:0]  Y1,
  input  logic [3:0]  Y2,
  input  logic [1:0]  write,
  input  logic        const_c,
  input  logic [31:0] constant,
  input  logic        pc_inc,
  input  logic [3:0]  copy_select,
  output logic [31:0] pc
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MUL = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_t;

  logic [31:0] registers [16];

  logic [31:0] x_op;
  logic [31:0] z_op;
  logic [31:0] y2_cur;
  logic [31:0] d_val;
  logic [63:0] product;
  logic [31:0] r1;
  logic [31:0] r2;

  // Byte-sliced add/sub. The carry (or borrow, via invert-plus-one) is
  // re-seeded at every lane boundary so lanes never interfere.
  function automatic logic [31:0] lane_addsub(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        sub,
                                              input logic [1:0]  mode);
    logic [31:0] bb;
    logic [31:0] res;
    logic [8:0]  s;
    logic        cin;
    logic        boundary;
    bb  = sub ? ~b : b;
    res = '0;
    cin = sub;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[8*i +: 8]} + {1'b0, bb[8*i +: 8]} + {8'b0, cin};
      res[8*i +: 8] = s[7:0];
      boundary = (mode == 2'b10) || ((mode == 2'b01) && (i == 1));
      cin = boundary ? sub : s[8];
    end
    return res;
  endfunction

  // Operand fetch; r0 is forced to read zero.
  always_comb begin
    x_op   = (A  == 4'd0) ? 32'd0 : registers[A];
    d_val  = (D  == 4'd0) ? 32'd0 : registers[D];
    y2_cur = (Y2 == 4'd0) ? 32'd0 : registers[Y2];
    if (const_c)
      z_op = constant;
    else if (form)
      z_op = (B == 4'd0) ? 32'd0 : registers[B];
    else
      z_op = (C == 4'd0) ? 32'd0 : registers[C];
  end

  assign product = {32'd0, x_op} * {32'd0, z_op};

  // Primary result. Bitwise ops are lane-agnostic, so vec only matters
  // for add and sub.
  always_comb begin
    r1 = '0;
    case (op_t'(op))
      OP_ADD: r1 = lane_addsub(x_op, z_op, 1'b0, vec);
      OP_SUB: r1 = lane_addsub(x_op, z_op, 1'b1, vec);
      OP_AND: r1 = x_op & z_op;
      OP_OR:  r1 = x_op | z_op;
      OP_MUL: r1 = product[31:0];
      OP_XOR: r1 = x_op ^ z_op;
      OP_SHL: r1 = x_op << z_op[4:0];
      OP_SHR: r1 = x_op >> z_op[4:0];
      default: r1 = '0;
    endcase
  end

  // Secondary result: multiply high word, otherwise a byte merge of
  // reg[D] into the current contents of reg[Y2].
  always_comb begin
    r2 = y2_cur;
    if (op == OP_MUL) begin
      r2 = product[63:32];
    end else begin
      for (int i = 0; i < 4; i++)
        if (copy_select[i])
          r2[8*i +: 8] = d_val[8*i +: 8];
    end
  end

  // Writeback. Statement order sets priority: the PC increment is
  // overridden by any write to r15, and the Y2 write beats Y1 on a clash.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++)
        registers[i] <= '0;
    end else begin
      if (pc_inc)
        registers[15] <= registers[15] + 32'd4;
      if (write[0] && (Y1 != 4'd0))
        registers[Y1] <= r1;
      if (write[1] && (Y2 != 4'd0))
        registers[Y2] <= r2;
    end
  end

  assign pc = registers[15];

endmodule

// File: tb/tb_datapath.sv
// ---------------------------------------------------------------------------
// tb_datapath
//   Directed self-checking bench for datapath. Inputs change 1 ns after a
//   rising edge, and each check is taken 1 ns after the following edge.
// ---------------------------------------------------------------------------
module tb_datapath;

  logic        clk;
  logic        rst;
  logic [2:0]  op;
  logic        form;
  logic [1:0]  vec;
  logic [3:0]  A, B, C, D, Y1, Y2;
  logic [1:0]  write;
  logic        const_c;
  logic [31:0] constant;
  logic        pc_inc;
  logic [3:0]  copy_select;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  datapath dut (
    .clk(clk), .rst(rst), .op(op), .form(form), .vec(vec),
    .A(A), .B(B), .C(C), .D(D), .Y1(Y1), .Y2(Y2),
    .write(write), .const_c(const_c), .constant(constant),
    .pc_inc(pc_inc), .copy_select(copy_select), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Let one rising edge happen, then settle 1 ns before checking.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic setIdle();
    rst = 0; op = 3'b000; form = 0; vec = 2'b00;
    A = 0; B = 0; C = 0; D = 0; Y1 = 0; Y2 = 0;
    write = 2'b00; const_c = 0; constant = 0; pc_inc = 0; copy_select = 0;
  endtask

  task automatic loadConst(input logic [3:0] idx, input logic [31:0] value);
    setIdle();
    A = 0; const_c = 1; constant = value; Y1 = idx; write = 2'b01;
    applyStimulus();
    setIdle();
  endtask

  task automatic aluConst(input logic [2:0] o, input logic [1:0] v,
                          input logic [3:0] a, input logic [31:0] k,
                          input logic [3:0] y);
    setIdle();
    op = o; vec = v; A = a; const_c = 1; constant = k; Y1 = y; write = 2'b01;
    applyStimulus();
    setIdle();
  endtask

  initial begin
    $display("[TB] starting datapath directed test");
    setIdle();
    rst = 1;
    applyStimulus();
    checkOutput("reset_pc", pc, 32'd0);
    checkOutput("reset_r1", dut.registers[1], 32'd0);
    rst = 0;

    // Constant loads
    loadConst(4'd1, 32'd5);
    checkOutput("const_r1", dut.registers[1], 32'd5);
    loadConst(4'd2, 32'd7);
    checkOutput("const_r2", dut.registers[2], 32'd7);
    checkOutput("const_r1_hold", dut.registers[1], 32'd5);

    // Write gating with const_c toggling
    for (int i = 0; i < 4; i++) begin
      setIdle();
      A = 1; C = 2; Y1 = 3; const_c = i[0]; constant = 32'hFFFF_FFFF;
      applyStimulus();
    end
    checkOutput("gate_r1", dut.registers[1], 32'd5);
    checkOutput("gate_r2", dut.registers[2], 32'd7);
    checkOutput("gate_r3", dut.registers[3], 32'd0);

    // Register add: 5 + 7
    setIdle();
    op = 3'b000; A = 1; C = 2; B = 4'd9; form = 0; Y1 = 3; write = 2'b01;
    applyStimulus();
    checkOutput("add_r3", dut.registers[3], 32'd12);

    // Multiply high word of 12*5 via form=1 (reg[B])
    setIdle();
    op = 3'b100; form = 1; A = 3; B = 1; C = 2; Y2 = 3; write = 2'b10;
    copy_select = 4'b1111; D = 2;
    applyStimulus();
    checkOutput("mulhi_r3", dut.registers[3], 32'd0);
    checkOutput("mul_r1_hold", dut.registers[1], 32'd5);
    checkOutput("mul_r2_hold", dut.registers[2], 32'd7);

    // 0xFFFFFFFF * 2: low 0xFFFFFFFE, high 1
    loadConst(4'd4, 32'hFFFF_FFFF);
    setIdle();
    op = 3'b100; A = 4; const_c = 1; constant = 32'd2; Y1 = 5; Y2 = 6;
    write = 2'b11;
    applyStimulus();
    checkOutput("mullo_r5", dut.registers[5], 32'hFFFF_FFFE);
    checkOutput("mulhi_r6", dut.registers[6], 32'd1);

    // PC behaviour
    setIdle();
    applyStimulus();
    checkOutput("pc_hold", pc, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      setIdle();
      pc_inc = 1;
      applyStimulus();
      checkOutput("pc_inc", pc, 32'(4 * i));
    end
    checkOutput("pc_r2_hold", dut.registers[2], 32'd7);
    setIdle();
    pc_inc = 1; A = 0; const_c = 1; constant = 32'h100; Y1 = 15; write = 2'b01;
    applyStimulus();
    checkOutput("pc_write_wins", pc, 32'h100);
    setIdle();
    pc_inc = 1;
    applyStimulus();
    checkOutput("pc_after_write", pc, 32'h104);
    loadConst(4'd15, 32'hFFFF_FFFC);
    pc_inc = 1;
    applyStimulus();
    checkOutput("pc_wrap", pc, 32'd0);

    // r0 writes are discarded
    loadConst(4'd0, 32'hDEAD_BEEF);
    checkOutput("r0_zero", dut.registers[0], 32'd0);

    // Lane arithmetic
    loadConst(4'd7, 32'h0000_00FF);
    aluConst(3'b000, 2'b10, 4'd7, 32'd1, 4'd9);
    checkOutput("add_vec8", dut.registers[9], 32'h0000_0000);
    aluConst(3'b000, 2'b01, 4'd7, 32'd1, 4'd9);
    checkOutput("add_vec16", dut.registers[9], 32'h0000_0100);
    aluConst(3'b000, 2'b11, 4'd7, 32'd1, 4'd9);
    checkOutput("add_vec11", dut.registers[9], 32'h0000_0100);
    loadConst(4'd10, 32'h0001_0000);
    aluConst(3'b001, 2'b01, 4'd10, 32'd1, 4'd9);
    checkOutput("sub_vec16", dut.registers[9], 32'h0001_FFFF);
    aluConst(3'b001, 2'b00, 4'd10, 32'd1, 4'd9);
    checkOutput("sub_vec32", dut.registers[9], 32'h0000_FFFF);
    aluConst(3'b001, 2'b10, 4'd10, 32'h0101_0101, 4'd9);
    checkOutput("sub_vec8", dut.registers[9], 32'hFF00_FFFF);

    // Logic and shifts
    aluConst(3'b010, 2'b00, 4'd7, 32'h0000_003C, 4'd9);
    checkOutput("and", dut.registers[9], 32'h0000_003C);
    aluConst(3'b011, 2'b00, 4'd1, 32'h0000_000A, 4'd9);
    checkOutput("or", dut.registers[9], 32'h0000_000F);
    aluConst(3'b101, 2'b00, 4'd7, 32'h0000_000F, 4'd9);
    checkOutput("xor", dut.registers[9], 32'h0000_00F0);
    aluConst(3'b110, 2'b10, 4'd1, 32'd4, 4'd9);
    checkOutput("shl", dut.registers[9], 32'h0000_0050);
    aluConst(3'b111, 2'b00, 4'd7, 32'h0000_0024, 4'd9);
    checkOutput("shr", dut.registers[9], 32'h0000_000F);

    // Byte-merge copy into Y2
    loadConst(4'd11, 32'hAABB_CCDD);
    loadConst(4'd12, 32'h1122_3344);
    setIdle();
    op = 3'b000; Y2 = 12; D = 11; copy_select = 4'b0101; write = 2'b10;
    applyStimulus();
    checkOutput("copy_merge", dut.registers[12], 32'h11BB_33DD);

    // Y1 == Y2 with both writes: Y2 wins
    setIdle();
    op = 3'b000; A = 0; const_c = 1; constant = 32'h55; Y1 = 13; Y2 = 13;
    D = 11; copy_select = 4'b1111; write = 2'b11;
    applyStimulus();
    checkOutput("y2_wins", dut.registers[13], 32'hAABB_CCDD);

    // Reset mid-sequence overrides an active write and increment
    setIdle();
    rst = 1; pc_inc = 1; A = 0; const_c = 1; constant = 32'h77; Y1 = 11;
    write = 2'b01;
    applyStimulus();
    setIdle();
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("rst_r%0d", i), dut.registers[i], 32'd0);
    checkOutput("rst_pc", pc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- 32-bit execution datapath: 16-entry x 32-bit register file plus an ALU/multiplier, driven each cycle by decoded control fields from the sequencer.
- Register 15 doubles as the program counter.
- Benches inspect state hierarchically, so the register array is named `registers` (`registers[0]`..`registers[15]`, each 32 bits).

Parameters:
- None. Widths are fixed at 32-bit data, 16 registers and 4-bit register addresses.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- op  input  3  ALU operation select
- form  input  1  second-operand form select
- vec  input  2  lane mode for add/sub/logic ops
- A  input  4  first-operand register address
- B  input  4  alternate second-operand register address
- C  input  4  second-operand register address
- D  input  4  copy-source register address
- Y1  input  4  primary destination register
- Y2  input  4  secondary destination register
- write  input  2  bit0 = write Y1, bit1 = write Y2
- const_c  input  1  1: second operand is `constant`
- constant  input  32  immediate value
- pc_inc  input  1  1: increment PC this cycle
- copy_select  input  4  byte mask for Y2 copy
- pc  output  32  current value of registers[15]

Behaviour:
- Reset:
  - rst=1 at a rising edge clears all 16 registers (pc=0).
  - rst has priority over every other write.
- Reads are combinational. registers[0] always reads 0; writes to it are discarded.
- Operand X = reg[A].
- Operand Z:
  - const_c=1 → constant, regardless of form.
  - const_c=0, form=0 → reg[C].
  - const_c=0, form=1 → reg[B].
- op encoding, giving R1 (primary result):
  - 000 → X+Z
  - 001 → X−Z
  - 010 → X&Z
  - 011 → X|Z
  - 100 → mul: unsigned 64-bit X*Z; R1 = low 32 bits, RH = high 32 bits
  - 101 → X^Z
  - 110 → X<<Z[4:0]
  - 111 → X>>Z[4:0] (logical)
- Arithmetic is modulo 2^32; no flags.
- vec lane mode (add/sub/and/or/xor only):
  - 00 or 11 → one 32-bit lane.
  - 01 → two independent 16-bit lanes.
  - 10 → four independent 8-bit lanes.
  - No carry/borrow crosses lane boundaries.
  - mul and shifts ignore vec.
- Y2 data, R2:
  - op=100 → RH; copy_select and D are ignored.
  - Otherwise → per byte i: copy_select[i] ? byte i of reg[D] : byte i of current reg[Y2].
- Writeback at rising edge:
  - write[0] → reg[Y1] ← R1.
  - write[1] → reg[Y2] ← R2.
- Y1==Y2 with both write bits set: Y2 write wins.
- PC (register 15), at each edge with rst=0:
  - If r15 is targeted by an enabled write, the written value wins.
  - Else if pc_inc=1, r15 ← r15+4 (wraps modulo 2^32).
  - Else r15 holds.
- Registers not addressed by an enabled write hold their value.
- Latency: results appear in the register file one edge after inputs are stable.
- There is no internal pipelining; a dependent operation can issue on the next cycle.

Test Plan:
- Constant load: A=0, const_c=1, constant=5, Y1=1, write=01 → registers[1]=5. Then constant=7, Y1=2 → registers[2]=7, registers[1] still 5.
- Write gating: A=1, C=2, Y1=3, write=00 for several cycles with const_c toggled → registers[1..3] unchanged.
- Register add: A=1, C=2, const_c=0, form=0, op=000, Y1=3, write=01 → registers[3]=12.
- Multiply high word: op=100, form=1, A=3, B=1, Y2=3, write=10 → registers[3]=0 (high word of 12*5); registers[1]=5 and registers[2]=7 unchanged. Repeat with 0xFFFFFFFF*2 → high word 1.
- PC behaviour: write=00, pc_inc=0 → no register changes. pc_inc=1 → pc advances by 4 per cycle; registers[2] stays 7. An explicit write to r15 overrides the increment.
- Reset, r0 and lanes:
  - rst=1 mid-sequence → all registers 0 after one edge.
  - Writing r0 → still reads 0.
  - vec=10 add of 0x000000FF+0x00000001 → 0x00000000.
  - copy with copy_select=0101 merges bytes 0 and 2 from reg[D].
